// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pattern generator and VGA pins.
interface vga_timing_gen_if;
  logic       h_sync;
  logic       v_sync;
  logic [9:0] col;
  logic [8:0] row;
  logic       video_on;
  logic       frame_start;

  modport master (
    output h_sync,
    output v_sync,
    output col,
    output row,
    output video_on,
    output frame_start
  );

  modport slave (
    input h_sync,
    input v_sync,
    input col,
    input row,
    input video_on,
    input frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters decoded into registered, mutually aligned outputs.
// Optional macro CLK_DIV2_EN: pixel ticks on every second clock (50 MHz clock, 25 MHz pixels).
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input logic              clock,
  input logic              reset_n,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Phase boundaries: each is the first count of the following phase.
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BACK_BEG = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BACK_BEG = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);

  localparam logic [1:0] PH_ACTIVE = 2'd0;
  localparam logic [1:0] PH_FRONT  = 2'd1;
  localparam logic [1:0] PH_SYNC   = 2'd2;
  localparam logic [1:0] PH_BACK   = 2'd3;

  logic       tick;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [1:0] h_phase, v_phase;

  logic       h_sync_q, h_sync_d;
  logic       v_sync_q, v_sync_d;
  logic [9:0] col_q, col_d;
  logic [8:0] row_q, row_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;

`ifdef CLK_DIV2_EN
  // Enable is 0 on the first edge after reset, so the first pixel tick lands on the second edge.
  logic pix_en_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_en_q <= 1'b0;
    end else begin
      pix_en_q <= ~pix_en_q;
    end
  end

  assign tick = pix_en_q;
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_MAX) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_comb begin
    if (h_cnt_q < H_ACT_END) begin
      h_phase = PH_ACTIVE;
    end else if (h_cnt_q < H_SYNC_BEG) begin
      h_phase = PH_FRONT;
    end else if (h_cnt_q < H_BACK_BEG) begin
      h_phase = PH_SYNC;
    end else begin
      h_phase = PH_BACK;
    end

    if (v_cnt_q < V_ACT_END) begin
      v_phase = PH_ACTIVE;
    end else if (v_cnt_q < V_SYNC_BEG) begin
      v_phase = PH_FRONT;
    end else if (v_cnt_q < V_BACK_BEG) begin
      v_phase = PH_SYNC;
    end else begin
      v_phase = PH_BACK;
    end
  end

  // All outputs decode the same counter snapshot so they stay mutually aligned.
  always_comb begin
    video_on_d    = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    col_d         = video_on_d ? h_cnt_q : '0;
    row_d         = video_on_d ? v_cnt_q[8:0] : '0;
    h_sync_d      = (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    v_sync_d      = (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_sync_q      <= ~SYNC_POL;
      v_sync_q      <= ~SYNC_POL;
      col_q         <= '0;
      row_q         <= '0;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (tick) begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      col_q         <= col_d;
      row_q         <= row_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.h_sync      = h_sync_q;
  assign vga.v_sync      = v_sync_q;
  assign vga.col         = col_q;
  assign vga.row         = row_q;
  assign vga.video_on    = video_on_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size instance for line timing, short-frame
// instance (10 lines) for frame, v_sync and mid-frame reset behaviour.
`timescale 1ns/1ps
module tb_vga_timing_gen;

`ifdef CLK_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  vga_timing_gen_if bus_full ();
  vga_timing_gen_if bus_small ();

  vga_timing_gen u_full (
    .clock   (clock),
    .reset_n (reset_n),
    .vga     (bus_full)
  );

  // Short frame: lines 0..3 active, 4..5 front porch, 6..7 sync, 8..9 back porch.
  vga_timing_gen #(
    .V_ACTIVE (4),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2)
  ) u_small (
    .clock   (clock),
    .reset_n (reset_n),
    .vga     (bus_small)
  );

  always #5 clock = ~clock;

  task automatic wait_tick();
    repeat (DIV) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus_full.h_sync !== 1'b1) begin
      failures++;
      $display("FAIL reset_h_sync got=%b want=1", bus_full.h_sync);
    end
    checks++;
    if (bus_full.v_sync !== 1'b1) begin
      failures++;
      $display("FAIL reset_v_sync got=%b want=1", bus_full.v_sync);
    end
    checks++;
    if (bus_full.col !== 10'd0) begin
      failures++;
      $display("FAIL reset_col got=%0d want=0", bus_full.col);
    end
    checks++;
    if (bus_full.row !== 9'd0) begin
      failures++;
      $display("FAIL reset_row got=%0d want=0", bus_full.row);
    end
    checks++;
    if (bus_full.video_on !== 1'b0) begin
      failures++;
      $display("FAIL reset_video_on got=%b want=0", bus_full.video_on);
    end
    checks++;
    if (bus_full.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_frame_start got=%b want=0", bus_full.frame_start);
    end
    checks++;
    if ({bus_small.h_sync, bus_small.v_sync, bus_small.video_on, bus_small.frame_start}
        !== 4'b1100) begin
      failures++;
      $display("FAIL reset_small_flags got=%b want=1100",
               {bus_small.h_sync, bus_small.v_sync, bus_small.video_on, bus_small.frame_start});
    end
  endtask

  // Releases reset and checks the first 800 ticks of the full-size instance.
  task automatic test_first_line(input string tag);
    int bad_vid = -1, bad_col = -1, bad_row = -1, bad_fs = -1, bad_hs = -1, bad_vs = -1;
    logic       exp_vid, exp_hs, exp_fs;
    logic [9:0] exp_col;
    @(negedge clock);
    reset_n = 1'b1;
    for (int t = 1; t <= 800; t++) begin
      wait_tick();
      exp_vid = (t <= 640);
      exp_col = exp_vid ? 10'(t - 1) : 10'd0;
      exp_hs  = !(t >= 657 && t <= 752);
      exp_fs  = (t == 1);
      if (bus_full.video_on !== exp_vid && bad_vid < 0) bad_vid = t;
      if (bus_full.col !== exp_col && bad_col < 0) bad_col = t;
      if (bus_full.row !== 9'd0 && bad_row < 0) bad_row = t;
      if (bus_full.frame_start !== exp_fs && bad_fs < 0) bad_fs = t;
      if (bus_full.h_sync !== exp_hs && bad_hs < 0) bad_hs = t;
      if (bus_full.v_sync !== 1'b1 && bad_vs < 0) bad_vs = t;
    end
    checks++;
    if (bad_vid != -1) begin
      failures++;
      $display("FAIL %s_video_on first_bad_tick=%0d want=none", tag, bad_vid);
    end
    checks++;
    if (bad_col != -1) begin
      failures++;
      $display("FAIL %s_col first_bad_tick=%0d want=none", tag, bad_col);
    end
    checks++;
    if (bad_row != -1) begin
      failures++;
      $display("FAIL %s_row first_bad_tick=%0d want=none", tag, bad_row);
    end
    checks++;
    if (bad_fs != -1) begin
      failures++;
      $display("FAIL %s_frame_start first_bad_tick=%0d want=none", tag, bad_fs);
    end
    checks++;
    if (bad_hs != -1) begin
      failures++;
      $display("FAIL %s_h_sync first_bad_tick=%0d want=none", tag, bad_hs);
    end
    checks++;
    if (bad_vs != -1) begin
      failures++;
      $display("FAIL %s_v_sync first_bad_tick=%0d want=none", tag, bad_vs);
    end
  endtask

  // Lines 1 and 2 of the full-size instance, continuing straight from test_first_line.
  task automatic test_hsync();
    int   col0 = -1, fall1 = -1, fall2 = -1, run = 0, max_run = 0;
    logic prev_hs = 1'b1;
    logic [8:0] row_l1 = '1, row_l2 = '1;
    for (int k = 1; k <= 1600; k++) begin
      wait_tick();
      if (bus_full.video_on === 1'b1 && bus_full.col === 10'd0 && col0 < 0) col0 = k;
      if (prev_hs === 1'b1 && bus_full.h_sync === 1'b0) begin
        if (fall1 < 0) fall1 = k;
        else if (fall2 < 0) fall2 = k;
      end
      run = (bus_full.h_sync === 1'b0) ? run + 1 : 0;
      if (run > max_run) max_run = run;
      prev_hs = bus_full.h_sync;
      if (k == 1) row_l1 = bus_full.row;
      if (k == 801) row_l2 = bus_full.row;
    end
    checks++;
    if (col0 != 1) begin
      failures++;
      $display("FAIL hsync_col0_tick got=%0d want=1", col0);
    end
    checks++;
    if (fall1 - col0 != 656) begin
      failures++;
      $display("FAIL hsync_offset got=%0d want=656", fall1 - col0);
    end
    checks++;
    if (fall2 - fall1 != 800) begin
      failures++;
      $display("FAIL hsync_period got=%0d want=800", fall2 - fall1);
    end
    checks++;
    if (max_run != 96) begin
      failures++;
      $display("FAIL hsync_width got=%0d want=96", max_run);
    end
    checks++;
    if (row_l1 !== 9'd1) begin
      failures++;
      $display("FAIL hsync_row_line1 got=%0d want=1", row_l1);
    end
    checks++;
    if (row_l2 !== 9'd2) begin
      failures++;
      $display("FAIL hsync_row_line2 got=%0d want=2", row_l2);
    end
  endtask

  // One whole short frame, aligned on a frame_start of the small instance.
  task automatic test_frame();
    int found = 0, bad_vid = -1, bad_row = -1, bad_col = -1, bad_vs = -1;
    int vs_low = 0, fs_count = 0, line = 0, h = 0;
    logic       exp_vid, exp_vs;
    logic [8:0] exp_row, last_row = '1;
    logic [9:0] exp_col;
    logic       fs_end = 1'b0;
    for (int i = 0; i < 8100 && found == 0; i++) begin
      wait_tick();
      if (bus_small.frame_start === 1'b1) found = 1;
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL frame_start_seen got=0 want=1");
      return;
    end
    for (int k = 1; k <= 8000; k++) begin
      wait_tick();
      h       = k % 800;
      line    = (k / 800) % 10;
      exp_vid = (h < 640) && (line < 4);
      exp_row = exp_vid ? 9'(line) : 9'd0;
      exp_col = exp_vid ? 10'(h) : 10'd0;
      exp_vs  = !(line == 6 || line == 7);
      if (bus_small.video_on !== exp_vid && bad_vid < 0) bad_vid = k;
      if (bus_small.row !== exp_row && bad_row < 0) bad_row = k;
      if (bus_small.col !== exp_col && bad_col < 0) bad_col = k;
      if (bus_small.v_sync !== exp_vs && bad_vs < 0) bad_vs = k;
      if (bus_small.v_sync === 1'b0) vs_low++;
      if (bus_small.frame_start === 1'b1) fs_count++;
      if (k == 3 * 800 + 1) last_row = bus_small.row;
      if (k == 8000) fs_end = bus_small.frame_start;
    end
    checks++;
    if (bad_vid != -1) begin
      failures++;
      $display("FAIL frame_video_on first_bad_tick=%0d want=none", bad_vid);
    end
    checks++;
    if (bad_row != -1) begin
      failures++;
      $display("FAIL frame_row first_bad_tick=%0d want=none", bad_row);
    end
    checks++;
    if (bad_col != -1) begin
      failures++;
      $display("FAIL frame_col first_bad_tick=%0d want=none", bad_col);
    end
    checks++;
    if (bad_vs != -1) begin
      failures++;
      $display("FAIL frame_v_sync first_bad_tick=%0d want=none", bad_vs);
    end
    checks++;
    if (vs_low != 1600) begin
      failures++;
      $display("FAIL frame_v_sync_low_ticks got=%0d want=1600", vs_low);
    end
    checks++;
    if (fs_count != 1 || fs_end !== 1'b1) begin
      failures++;
      $display("FAIL frame_start_period count=%0d at_8000=%b want count=1 at_8000=1",
               fs_count, fs_end);
    end
    checks++;
    if (last_row !== 9'd3) begin
      failures++;
      $display("FAIL frame_last_active_row got=%0d want=3", last_row);
    end
  endtask

  // Counters of the small instance sit at h=700, v=6 (inside both syncs) when reset hits.
  task automatic test_mid_reset();
    repeat (5499) wait_tick();
    checks++;
    if (bus_small.h_sync !== 1'b0 || bus_small.v_sync !== 1'b0) begin
      failures++;
      $display("FAIL midrst_pre_sync got h=%b v=%b want h=0 v=0",
               bus_small.h_sync, bus_small.v_sync);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus_small.h_sync !== 1'b1 || bus_small.v_sync !== 1'b1) begin
      failures++;
      $display("FAIL midrst_async_sync got h=%b v=%b want h=1 v=1",
               bus_small.h_sync, bus_small.v_sync);
    end
    checks++;
    if (bus_small.video_on !== 1'b0 || bus_small.row !== 9'd0 || bus_small.col !== 10'd0) begin
      failures++;
      $display("FAIL midrst_async_video got vid=%b row=%0d col=%0d want vid=0 row=0 col=0",
               bus_small.video_on, bus_small.row, bus_small.col);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus_full.h_sync !== 1'b1 || bus_full.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL midrst_held got h=%b fs=%b want h=1 fs=0",
               bus_full.h_sync, bus_full.frame_start);
    end
  endtask

  initial begin
    test_reset();
    test_first_line("first_line");
    test_hsync();
    test_frame();
    test_mid_reset();
    test_first_line("restart");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
